nibble_serial_add_ctrl: RTL and testbench

Sequencer and arbiter for one shared 4-bit ripple-carry adder stage. It accepts wide addition jobs from two requesters and grants them round-robin. Each job runs one nibble per clock through the 4-bit stage, with the carry chained between nibbles through a register. It returns the full-width sum, carry-out and owner ID with a one-cycle done pulse. It sits between client logic and the 4-bit adder datapath, so wide adds reuse the existing adder instead of instantiating a wide one.

---
 rtl/nibble_serial_add_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Two-requester round-robin sequencer for a shared 4-bit adder stage.
// Wide sums are built one nibble per clock, LSB first, carry chained.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req0/a0/b0       requester 0 job request and operands
//   req1/a1/b1       requester 1 job request and operands
//   grant0/grant1    one-cycle acceptance pulses
//   busy             job in flight (acceptance through done)
//   done             one-cycle pulse; result/carry_out/owner valid
//   result           W-bit sum of the last completed job
//   carry_out        carry out of the MSB nibble
//   owner            requester of the last completed job
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [4*NIBBLES-1:0] a0,
  input  logic [4*NIBBLES-1:0] b0,
  input  logic                 req1,
  input  logic [4*NIBBLES-1:0] a1,
  input  logic [4*NIBBLES-1:0] b1,
  output logic                 grant0,
  output logic                 grant1,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 owner
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IW-1:0] idx_q;
  logic [W-1:0]  opa_q;
  logic [W-1:0]  opb_q;
  logic [W-1:0]  sum_q;
  logic          carry_q;
  logic          job_owner_q;
  logic          last_owner_q;

  logic          grant0_q;
  logic          grant1_q;
  logic          done_q;
  logic [W-1:0]  result_q;
  logic          carry_out_q;
  logic          owner_q;

  logic          accept;
  logic          win0;
  logic          win1;
  logic          step_en;
  logic          finish;
  logic          last_nib;

  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [4:0]    nib_sum;

  assign last_nib = (idx_q == IW'(NIBBLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last_nib) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control strobes; arbitration only in IDLE.
  // On a tie the requester that did not win last time goes.
  always_comb begin
    accept  = 1'b0;
    win0    = 1'b0;
    win1    = 1'b0;
    step_en = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        accept = req0 | req1;
        unique case (1'b1)
          (req0 && !req1): win0 = 1'b1;
          (req1 && !req0): win1 = 1'b1;
          (req0 && req1): begin
            win0 = last_owner_q;
            win1 = ~last_owner_q;
          end
          default: ;
        endcase
      end
      S_RUN:   step_en = 1'b1;
      S_DONE:  finish  = 1'b1;
      default: ;
    endcase
  end

  // Nibble select for the current index
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        nib_a = opa_q[4*i +: 4];
        nib_b = opb_q[4*i +: 4];
      end
    end
  end

  // The shared 4-bit adder stage
  assign nib_sum = {1'b0, nib_a}
                 + {1'b0, nib_b}
                 + {4'b0000, carry_q};

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      job_owner_q  <= 1'b0;
      last_owner_q <= 1'b1;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      carry_out_q  <= 1'b0;
      owner_q      <= 1'b0;
    end else begin
      grant0_q <= win0;
      grant1_q <= win1;
      done_q   <= finish;

      if (accept) begin
        opa_q        <= win1 ? a1 : a0;
        opb_q        <= win1 ? b1 : b0;
        sum_q        <= '0;
        idx_q        <= '0;
        carry_q      <= 1'b0;
        job_owner_q  <= win1;
        last_owner_q <= win1;
      end

      if (step_en) begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IW'(i)) begin
            sum_q[4*i +: 4] <= nib_sum[3:0];
          end
        end
        carry_q <= nib_sum[4];
        idx_q   <= idx_q + 1'b1;
      end

      if (finish) begin
        result_q    <= sum_q;
        carry_out_q <= carry_q;
        owner_q     <= job_owner_q;
      end
    end
  end

  // busy covers RUN, DONE and the done-pulse cycle
  assign busy      = (state_q != S_IDLE) | done_q;
  assign grant0    = grant0_q;
  assign grant1    = grant1_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl at NIBBLES=4.
// Expected values are hand-computed constants.
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0;
  logic        req1;
  logic [15:0] a0;
  logic [15:0] b0;
  logic [15:0] a1;
  logic [15:0] b1;
  logic        grant0;
  logic        grant1;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry_out;
  logic        owner;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .a0        (a0),
    .b0        (b0),
    .req1      (req1),
    .a1        (a1),
    .b1        (b1),
    .grant0    (grant0),
    .grant1    (grant1),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .owner     (owner)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_g0"},  32'(grant0),    0);
    chk({tag, "_g1"},  32'(grant1),    0);
    chk({tag, "_bsy"}, 32'(busy),      0);
    chk({tag, "_dn"},  32'(done),      0);
    chk({tag, "_res"}, 32'(result),    0);
    chk({tag, "_co"},  32'(carry_out), 0);
    chk({tag, "_own"}, 32'(owner),     0);
  endtask

  // Grants never overlap each other or done
  always @(negedge clk) begin
    chk("excl",
        32'({grant0 & grant1,
             done & (grant0 | grant1)}),
        0);
  end

  initial begin
    int n;
    int t_d;
    int t_g;
    int jobs;
    int gcnt;
    int got_d;

    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    a0 = '0; b0 = '0;
    a1 = '0; b1 = '0;
    step();
    step();
    chk_reset_state("rst");
    rst = 1'b0;

    // Single job
    a0 = 16'h1234; b0 = 16'h4321; req0 = 1'b1;
    step();
    chk("t1_grant0", 32'(grant0), 1);
    chk("t1_busy",   32'(busy),   1);
    req0 = 1'b0; a0 = '0; b0 = '0;
    wait_done(n);
    chk("t1_lat",   32'(n),         5);
    chk("t1_res",   32'(result),    'h5555);
    chk("t1_co",    32'(carry_out), 0);
    chk("t1_own",   32'(owner),     0);
    chk("t1_busyd", 32'(busy),      1);
    step();
    chk("t1_dnlow", 32'(done), 0);
    chk("t1_idle",  32'(busy), 0);

    // Full carry ripple
    a1 = 16'hFFFF; b1 = 16'h0001; req1 = 1'b1;
    step();
    chk("t2_grant1", 32'(grant1), 1);
    chk("t2_grant0", 32'(grant0), 0);
    req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_carry", 32'(dut.carry_q), 1);
    end
    step();
    chk("t2_done", 32'(done),      1);
    chk("t2_res",  32'(result),    0);
    chk("t2_co",   32'(carry_out), 1);
    chk("t2_own",  32'(owner),     1);
    step();

    // Tie after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    a0 = 16'h0001; b0 = 16'h0001;
    a1 = 16'h00F0; b1 = 16'h0010;
    req0 = 1'b1; req1 = 1'b1;
    step();
    chk("t3_g0", 32'(grant0), 1);
    chk("t3_g1", 32'(grant1), 0);
    req0 = 1'b0;
    wait_done(n);
    t_d = cyc;
    chk("t3_own0", 32'(owner),  0);
    chk("t3_res0", 32'(result), 'h0002);
    step();
    chk("t3_g1b", 32'(grant1), 1);
    req1 = 1'b0;
    wait_done(n);
    chk("t3_own1", 32'(owner),   1);
    chk("t3_res1", 32'(result),  'h0100);
    chk("t3_gap",  32'(cyc - t_d), 6);
    step();

    // Fairness under continuous contention
    a0 = 16'h0011; b0 = 16'h0022;
    a1 = 16'h0100; b1 = 16'h0200;
    req0 = 1'b1; req1 = 1'b1;
    jobs = 0;
    gcnt = 0;
    for (int i = 0; i < 80 && jobs < 6; i++) begin
      step();
      if (grant0 || grant1) begin
        chk("t4_galt", 32'(grant1), 32'(gcnt % 2));
        gcnt++;
      end
      if (done) begin
        chk("t4_own", 32'(owner), 32'(jobs % 2));
        chk("t4_res", 32'(result),
            (jobs % 2 == 0) ? 'h0033 : 'h0300);
        jobs++;
        if (jobs == 6) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    chk("t4_jobs",  32'(jobs), 6);
    chk("t4_grnts", 32'(gcnt), 6);
    step();

    // Busy rejection
    a0 = 16'h8000; b0 = 16'h8000; req0 = 1'b1;
    step();
    chk("t5_g0", 32'(grant0), 1);
    t_g = cyc;
    req0 = 1'b0;
    step();
    a1 = 16'h0003; b1 = 16'h0004; req1 = 1'b1;
    t_d = 0;
    got_d = 0;
    for (int i = 0; i < 20 && !grant1; i++) begin
      step();
      if (done) begin
        got_d = 1;
        t_d = cyc;
        chk("t5_res", 32'(result),    0);
        chk("t5_co",  32'(carry_out), 1);
        chk("t5_own", 32'(owner),     0);
      end
    end
    chk("t5_gotd",  32'(got_d),     1);
    chk("t5_dlat",  32'(t_d - t_g), 5);
    chk("t5_g1lat", 32'(cyc - t_g), 6);
    req1 = 1'b0;
    wait_done(n);
    chk("t5_res1", 32'(result), 'h0007);
    chk("t5_own1", 32'(owner),  1);
    step();

    // Reset mid-job
    a0 = 16'hABCD; b0 = 16'h1111; req0 = 1'b1;
    step();
    chk("t6_g0", 32'(grant0), 1);
    req0 = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("t6_rst");
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_quiet", 32'(done | grant0 | grant1 | busy), 0);
    end
    a0 = 16'h0F0F; b0 = 16'h00F1; req0 = 1'b1;
    step();
    chk("t6_g0b", 32'(grant0), 1);
    req0 = 1'b0;
    wait_done(n);
    chk("t6_lat", 32'(n),         5);
    chk("t6_res", 32'(result),    'h1000);
    chk("t6_co",  32'(carry_out), 0);
    chk("t6_own", 32'(owner),     0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
